// File: rtl/joy_scan.sv
// joy_scan: serial reader for the two DB9 joystick ports, wired through a
// 74HC165-style parallel-in/serial-out chain.
//
// Every POLL shift ticks the block runs two load/shift phases. Phase A runs
// with joyS=1 and phase B with joyS=0, so Genesis-type pads also report
// A and Start. Each phase parallel-loads the chain, then shifts in BITS bits
// MSB first. Bits [BITS-1:BITS-8] belong to port 1 and bits [7:0] to port 2.
// When the scan is complete, both 8-bit port states are registered together
// and strb pulses for one clock.
//
// Parameters:
//   CLKDIV - system clocks per shift tick (minimum 2)
//   BITS   - chain length per phase (at least 16)
//   POLL   - idle ticks between scans (at least 1)
//
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous reset, active low
//   joyCk  out  shift clock to the chain
//   joyLd  out  chain parallel load, active low
//   joyS   out  DB9 pin-7 select (1 = phase A, 0 = phase B)
//   joyD   in   serial data from the chain
//   joy1   out  port 1 state, active low (bit0 right .. bit3 up, bit4 B,
//               bit5 C, bit6 A, bit7 Start)
//   joy2   out  port 2 state, same layout
//   strb   out  one-clock pulse when joy1/joy2 update
//
// Optional build macro:
//   JOY_DEBOUNCE_EN - joy1/joy2 update (and strb pulses) only when a scan
//                     matches the previous scan's raw result.
module joy_scan #(
    parameter int CLKDIV = 28,
    parameter int BITS   = 16,
    parameter int POLL   = 1000
) (
    input  logic       clock,
    input  logic       reset,
    output logic       joyCk,
    output logic       joyLd,
    output logic       joyS,
    input  logic       joyD,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       strb
);

    localparam int DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int POLL_W = $clog2(POLL + 1);
    localparam int BIT_W  = $clog2(BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LOAD,
        SHIFT_HI,
        SHIFT_LO,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [POLL_W-1:0]   poll_cnt, poll_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [BITS-1:0]     sr, sr_n;
    logic                phase_b, phase_b_n;
    logic [5:0]          a_port1, a_port1_n;
    logic [5:0]          a_port2, a_port2_n;
    logic [7:0]          new1, new2;
    logic [7:0]          joy1_q, joy1_n;
    logic [7:0]          joy2_q, joy2_n;
    logic                strb_q, strb_n;
    logic                joy_ck, joy_ld, joy_s;
    logic                unused_bits;
`ifdef JOY_DEBOUNCE_EN
    logic [7:0]          prev1, prev1_n;
    logic [7:0]          prev2, prev2_n;
    logic                prev_valid, prev_valid_n;
`endif

    // Only the up/down/left/right/pin6/pin9 fields of each byte are decoded.
    assign unused_bits = ^{sr[BITS-7:8], sr[1:0]};

    // Builds the active-low output byte for one port.
    // a = phase-A {up, down, left, right, pin6, pin9}
    // b = phase-B {left, right, pin6, pin9}
    // A Genesis pad pulls left and right low in phase B; only then are the
    // phase-B pin6/pin9 lines meaningful as A and Start.
    function automatic logic [7:0] decode_port(input logic [5:0] a, input logic [3:0] b);
        logic genesis;
        genesis = ~b[3] & ~b[2];
        return {genesis ? b[0] : 1'b1, genesis ? b[1] : 1'b1,
                a[0], a[1], a[5], a[4], a[3], a[2]};
    endfunction

    // Free-running divider that produces one shift tick every CLKDIV clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_W'(CLKDIV - 1));

    assign new1 = decode_port(a_port1, sr[BITS-3 -: 4]);
    assign new2 = decode_port(a_port2, sr[5:2]);

    // Next-state logic. Every state except DONE waits for a tick.
    // DONE lasts exactly one clock, and because CLKDIV >= 2 it never
    // coincides with a tick.
    always_comb begin
        state_n   = state;
        poll_n    = poll_cnt;
        bit_n     = bit_cnt;
        sr_n      = sr;
        phase_b_n = phase_b;
        a_port1_n = a_port1;
        a_port2_n = a_port2;
        joy1_n    = joy1_q;
        joy2_n    = joy2_q;
        strb_n    = 1'b0;
`ifdef JOY_DEBOUNCE_EN
        prev1_n      = prev1;
        prev2_n      = prev2;
        prev_valid_n = prev_valid;
`endif
        case (state)
            IDLE: begin
                if (tick) begin
                    if (poll_cnt == POLL_W'(POLL - 1)) begin
                        poll_n  = '0;
                        state_n = SETTLE;
                    end else begin
                        poll_n = poll_cnt + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (tick) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                // The chain presents its MSB as soon as it is loaded, so the
                // first bit is taken as joyLd is released.
                if (tick) begin
                    sr_n    = {sr[BITS-2:0], joyD};
                    bit_n   = '0;
                    state_n = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    sr_n = {sr[BITS-2:0], joyD};
                    if (bit_cnt == BIT_W'(BITS - 2)) begin
                        if (!phase_b) begin
                            a_port1_n = sr_n[BITS-1 -: 6];
                            a_port2_n = sr_n[7:2];
                            phase_b_n = 1'b1;
                            state_n   = SETTLE;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        state_n = SHIFT_HI;
                    end
                end
            end
            DONE: begin
`ifdef JOY_DEBOUNCE_EN
                if (prev_valid && new1 == prev1 && new2 == prev2) begin
                    joy1_n = new1;
                    joy2_n = new2;
                    strb_n = 1'b1;
                end
                prev1_n      = new1;
                prev2_n      = new2;
                prev_valid_n = 1'b1;
`else
                joy1_n = new1;
                joy2_n = new2;
                strb_n = 1'b1;
`endif
                phase_b_n = 1'b0;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register. The chain-control pins are registered from the next
    // state so that they are glitch-free and change only on clock edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            poll_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            phase_b  <= 1'b0;
            a_port1  <= '1;
            a_port2  <= '1;
            joy1_q   <= 8'hFF;
            joy2_q   <= 8'hFF;
            strb_q   <= 1'b0;
            joy_ck   <= 1'b0;
            joy_ld   <= 1'b1;
            joy_s    <= 1'b1;
`ifdef JOY_DEBOUNCE_EN
            prev1      <= 8'hFF;
            prev2      <= 8'hFF;
            prev_valid <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            poll_cnt <= poll_n;
            bit_cnt  <= bit_n;
            sr       <= sr_n;
            phase_b  <= phase_b_n;
            a_port1  <= a_port1_n;
            a_port2  <= a_port2_n;
            joy1_q   <= joy1_n;
            joy2_q   <= joy2_n;
            strb_q   <= strb_n;
            joy_ck   <= (state_n == SHIFT_HI);
            joy_ld   <= (state_n != LOAD);
            joy_s    <= ~phase_b_n;
`ifdef JOY_DEBOUNCE_EN
            prev1      <= prev1_n;
            prev2      <= prev2_n;
            prev_valid <= prev_valid_n;
`endif
        end
    end

    assign joyCk = joy_ck;
    assign joyLd = joy_ld;
    assign joyS  = joy_s;
    assign joy1  = joy1_q;
    assign joy2  = joy2_q;
    assign strb  = strb_q;

endmodule

// File: tb/tb_joy_scan.sv
// tb_joy_scan: scoreboard bench for joy_scan.
// A behavioural 74HC165 chain feeds the DUT from two 16-bit pad words (one
// for joyS=1, one for joyS=0). Each scan's expected joy1/joy2 pair is
// computed from the pad words and queued. A monitor pops an entry on every
// strb and compares it with the outputs. The bench also honours
// JOY_DEBOUNCE_EN, if defined.
module tb_joy_scan;

    localparam int CLKDIV    = 4;
    localparam int BITS      = 16;
    localparam int POLL      = 2;
    localparam int SCAN_CLKS = (4 * BITS + POLL) * CLKDIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        joyCk, joyLd, joyS, joyD;
    logic [7:0]  joy1, joy2;
    logic        strb;

    logic [15:0] word_a = 16'hFFFF;
    logic [15:0] word_b = 16'hFFFF;
    logic [15:0] chain  = 16'hFFFF;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_out = 16'hFFFF;
`ifdef JOY_DEBOUNCE_EN
    logic [15:0] model_prev = 16'hFFFF;
    bit          model_prev_valid = 1'b0;
`endif

    always #5 clock = ~clock;

    joy_scan #(.CLKDIV(CLKDIV), .BITS(BITS), .POLL(POLL)) dut (
        .clock(clock),
        .reset(reset),
        .joyCk(joyCk),
        .joyLd(joyLd),
        .joyS (joyS),
        .joyD (joyD),
        .joy1 (joy1),
        .joy2 (joy2),
        .strb (strb)
    );

    // The shift-register chain: loads on joyLd falling and shifts toward Q on each joyCk rise.
    assign joyD = chain[15];
    always @(negedge joyLd or posedge joyCk) begin
        if (!joyLd) chain <= joyS ? word_a : word_b;
        else        chain <= {chain[14:0], 1'b1};
    end

    // Expected port byte, built from the pad's phase-A and phase-B bytes.
    function automatic logic [7:0] ref_port(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        bit genesis;
        genesis = (b[5] == 1'b0) && (b[4] == 1'b0);
        r[0] = a[4];
        r[1] = a[5];
        r[2] = a[6];
        r[3] = a[7];
        r[4] = a[3];
        r[5] = a[2];
        r[6] = genesis ? b[3] : 1'b1;
        r[7] = genesis ? b[2] : 1'b1;
        return r;
    endfunction

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Records one scan with the given pad words.
    task automatic model_scan(input logic [15:0] wa, input logic [15:0] wb);
        logic [15:0] pair;
        pair = {ref_port(wa[15:8], wb[15:8]), ref_port(wa[7:0], wb[7:0])};
`ifdef JOY_DEBOUNCE_EN
        if (model_prev_valid && pair == model_prev) begin
            exp_q.push_back(pair);
            model_out = pair;
        end
        model_prev       = pair;
        model_prev_valid = 1'b1;
`else
        exp_q.push_back(pair);
        model_out = pair;
`endif
    endtask

    task automatic apply_stimulus(input logic [15:0] wa, input logic [15:0] wb);
        word_a = wa;
        word_b = wb;
        model_scan(wa, wb);
    endtask

    task automatic check_output(input string name);
        check_value(name, {joy1, joy2}, model_out);
    endtask

    // Waits until joyS has gone low and come back high, which marks the end of a scan.
    task automatic wait_scan_end();
        bit seen_low = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clock);
            if (!joyS) seen_low = 1'b1;
            else if (seen_low) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL scan_end_timeout actual=none required=joyS_rise");
        end
    endtask

    // Releases reset and measures the clocks until the first strb. One extra
    // clock is spent in the DONE state after the last tick of the scan.
    task automatic release_and_measure(input string name);
        int cyc = 0;
        int expected;
        model_scan(word_a, word_b);
        model_scan(word_a, word_b);
`ifdef JOY_DEBOUNCE_EN
        expected = 2 * SCAN_CLKS + 1;
`else
        expected = SCAN_CLKS + 1;
`endif
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3 * SCAN_CLKS; i++) begin
            @(negedge clock);
            cyc++;
            if (strb) break;
        end
        check_value({name, "_first_strb_clocks"}, cyc, expected);
`ifndef JOY_DEBOUNCE_EN
        wait_scan_end();
`endif
        check_output({name, "_pair"});
    endtask

    // Watches the chain pins across one whole scan.
    task automatic check_timing();
        int ld_runs[$];
        int ld_s[$];
        int pulses[2] = '{0, 0};
        int bad_width = 0;
        int ld_run = 0, ck_run = 0, cyc = 0, s_fall = 0, s_rise = 0;
        bit seen_low = 1'b0, done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clock);
            cyc++;
            if (!joyLd) begin
                if (ld_run == 0) ld_s.push_back(int'(joyS));
                ld_run++;
            end else if (ld_run != 0) begin
                ld_runs.push_back(ld_run);
                ld_run = 0;
            end
            if (joyCk) begin
                ck_run++;
            end else if (ck_run != 0) begin
                if (ck_run != CLKDIV) bad_width++;
                pulses[seen_low ? 1 : 0]++;
                ck_run = 0;
            end
            if (!joyS && !seen_low) begin
                seen_low = 1'b1;
                s_fall = cyc;
            end else if (joyS && seen_low) begin
                s_rise = cyc;
                done = 1'b1;
            end
        end
        check_value("timing_scan_done", done, 1);
        check_value("timing_load_count", ld_runs.size(), 2);
        if (ld_runs.size() == 2) begin
            check_value("timing_load_a_width", ld_runs[0], CLKDIV);
            check_value("timing_load_b_width", ld_runs[1], CLKDIV);
            check_value("timing_load_a_sel", ld_s[0], 1);
            check_value("timing_load_b_sel", ld_s[1], 0);
        end
        check_value("timing_pulses_a", pulses[0], BITS - 1);
        check_value("timing_pulses_b", pulses[1], BITS - 1);
        check_value("timing_pulse_width_bad", bad_width, 0);
        check_value("timing_sel_low_clocks", s_rise - s_fall, 2 * BITS * CLKDIV + 1);
    endtask

    // Scoreboard monitor: every strb must match the oldest queued expectation.
    // The port outputs may change only together with strb.
    logic        prev_strb = 1'b0;
    logic [15:0] last_pair = 16'hFFFF;
    always @(negedge clock) begin
        logic [15:0] expv;
        if (reset) begin
            if (strb) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_strb actual=%h required=no_strb", {joy1, joy2});
                end else begin
                    expv = exp_q.pop_front();
                    check_value("scoreboard_pair", {joy1, joy2}, expv);
                end
                check_value("strb_one_clock", prev_strb, 0);
            end
            if ({joy1, joy2} != last_pair) check_value("change_with_strb", strb, 1);
        end
        prev_strb <= strb;
        last_pair <= {joy1, joy2};
    end

    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] wa, wb;
        int falls;
        logic prev_ck;
        #1 reset = 1'b0;
        repeat (5) @(negedge clock);
        check_value("reset_pins", {joyCk, joyLd, joyS, strb}, 4'b0110);
        check_value("reset_joy1", joy1, 8'hFF);
        check_value("reset_joy2", joy2, 8'hFF);

        // Idle pads, joyD stays high.
        release_and_measure("idle");

        // Port 1 up pressed.
        repeat (2) begin
            apply_stimulus(16'h7FFF, 16'hFFFF);
            wait_scan_end();
            check_output("up_pressed");
        end

        // Port 2 Genesis pad with A and Start pressed.
        repeat (2) begin
            apply_stimulus(16'hFFFF, 16'hFFC3);
            wait_scan_end();
            check_output("genesis_port2");
        end

        // Same phase-B byte with left released: not a Genesis pad.
        repeat (2) begin
            apply_stimulus(16'hFFFF, 16'hFFE3);
            wait_scan_end();
            check_output("no_genesis_port2");
        end

        // Chain timing on a combined pattern.
        apply_stimulus(16'h7FFF, 16'hFFC3);
        check_timing();
        check_output("timing_pair");
        apply_stimulus(16'h7FFF, 16'hFFC3);
        wait_scan_end();
        check_output("combined_pair");

        // Reset during a phase-B SHIFT_LO. The aborted scan is never queued.
        for (int i = 0; i < 2000 && joyS; i++) @(negedge clock);
        falls = 0;
        prev_ck = joyCk;
        for (int i = 0; i < 2000 && falls < 3; i++) begin
            @(negedge clock);
            if (prev_ck && !joyCk) falls++;
            prev_ck = joyCk;
        end
        check_value("reset_mid_reached", falls, 3);
        #2 reset = 1'b0;
        #1;
        check_value("abort_pins", {joyCk, joyLd, joyS, strb}, 4'b0110);
        check_value("abort_joy", {joy1, joy2}, 16'hFFFF);
        model_out = 16'hFFFF;
`ifdef JOY_DEBOUNCE_EN
        model_prev_valid = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check_value("abort_hold_pins", {joyCk, joyLd, joyS, strb}, 4'b0110);
        release_and_measure("after_abort");

        // Random pads, each repeated so that the debounced build also updates.
        for (int n = 0; n < 6; n++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            if ($urandom_range(0, 1) == 1) wb[13:12] = 2'b00;
            if ($urandom_range(0, 1) == 1) wb[5:4] = 2'b00;
            repeat (2) begin
                apply_stimulus(wa, wb);
                wait_scan_end();
                check_output("random_pair");
            end
        end

        repeat (4) @(negedge clock);
        check_value("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
